// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_WORD   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } loader_state_t;

    // Number of words an instruction memory of the given address width holds.
    function automatic logic [16:0] capacity_words(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
// word/word_valid are registered: they appear the cycle after the 4th byte.
// last_byte is combinational so the caller can act in the same cycle as the
// byte that completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_stb,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        valid_q, valid_d;

    assign last_byte  = byte_stb && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_valid = valid_q;
    assign word       = shift_q;

    // Next-state: shift MSB-first, counter wraps 3 -> 0 at each word boundary.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        if (clr) begin
            byte_cnt_d = 2'd0;
            shift_d    = 32'd0;
        end else if (byte_stb) begin
            shift_d    = {shift_q[23:0], byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
            valid_d    = last_byte;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// frame, writes the words into instruction memory from address 0 and releases
// the core only once the whole image has been verified.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_LEN_HI | waiting for high byte of the word count (reset state)
// S_LEN_LO | waiting for low byte; count checked against memory capacity
// S_WORD   | receiving payload bytes, one memory write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | image verified, core released; start restarts
// S_ERR    | overflow or bad checksum, core held; start restarts
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    // The length field is 16 bits, so a larger memory could never be filled.
    localparam logic [16:0] CAP_WORDS = capacity_words(ADDR_W);

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [7:0]        xor_q, xor_d;

    logic        byte_xfer;
    logic        restart;
    logic        asm_stb;
    logic        asm_last;
    logic        asm_valid;
    logic [31:0] asm_word;
    logic [16:0] len_in;
    logic        last_word;

    assign rx_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign byte_xfer = rx_valid && rx_ready;
    assign restart   = start && ((state_q == S_DONE) || (state_q == S_ERR));
    assign asm_stb   = byte_xfer && (state_q == S_WORD);
    assign len_in    = {1'b0, len_q[15:8], rx_data};
    assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .byte_stb   (asm_stb),
        .byte_in    (rx_data),
        .last_byte  (asm_last),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    // Frame parser: length capture, word counting, running XOR, verdict.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        imem_addr_d = imem_addr_q;
        xor_d       = xor_q;
        case (state_q)
            S_LEN_HI: begin
                if (byte_xfer) begin
                    len_d[15:8] = rx_data;
                    xor_d       = xor_q ^ rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_xfer) begin
                    len_d[7:0] = rx_data;
                    xor_d      = xor_q ^ rx_data;
                    if (len_in > CAP_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_in == 17'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_WORD;
                    end
                end
            end
            S_WORD: begin
                if (byte_xfer) begin
                    xor_d = xor_q ^ rx_data;
                    if (asm_last) begin
                        // Address lines up with the assembler's registered word.
                        imem_addr_d = word_cnt_q;
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (byte_xfer) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN_HI;
                    xor_d       = 8'd0;
                    word_cnt_d  = '0;
                    imem_addr_d = '0;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    // State registers; async reset returns to S_LEN_HI with the core held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LEN_HI;
            len_q       <= 16'd0;
            word_cnt_q  <= '0;
            imem_addr_q <= '0;
            xor_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            imem_addr_q <= imem_addr_d;
            xor_q       <= xor_d;
        end
    end

    assign imem_we    = asm_valid;
    assign imem_wdata = asm_word;
    assign imem_addr  = imem_addr_q;
    assign done       = (state_q == S_DONE);
    assign core_rst_n = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with a small (16-word) memory so the
// capacity boundary is reachable.
module tb_prog_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          error;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          lat_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] word_in[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next expected write, in order,
    // and arrive the cycle after its 4th byte transferred.
    wr_t mon_e;
    always @(negedge clk) begin
        if (rst && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 64'(imem_addr), 64'(mon_e.addr));
                chk("write_data", 64'(imem_wdata), 64'(mon_e.data));
                if (lat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_latency: write at cycle %0d with no 4th byte transferred", cyc);
                end else begin
                    chk("write_latency", 64'(cyc), 64'(lat_q.pop_front()));
                end
            end
        end
    end

    // Frame = length (n_len), the words in word_in, XOR checksum ^ flip.
    task automatic build_frame(input int n_len, input logic [7:0] flip);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'(n_len >> 8));
        frame_q.push_back(8'(n_len));
        foreach (word_in[w]) begin
            frame_q.push_back(word_in[w][31:24]);
            frame_q.push_back(word_in[w][23:16]);
            frame_q.push_back(word_in[w][15:8]);
            frame_q.push_back(word_in[w][7:0]);
        end
        x = 8'd0;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        frame_q.push_back(x ^ flip);
    endtask

    task automatic rand_words(input int n);
        word_in.delete();
        for (int i = 0; i < n; i++) word_in.push_back($urandom);
    endtask

    // Reference model decides how many bytes the loader accepts, which writes
    // result and the verdict; the driver then feeds the bytes with random gaps.
    // n_send < 0 sends the whole accepted frame.
    task automatic send_frame(input int gap_max, input int n_send, input bit start_mid);
        int  n, accept, gap;
        bit  ok, partial;
        logic [7:0] x;
        wr_t e;
        n = {frame_q[0], frame_q[1]};
        if (n > CAP) begin
            accept = 2;
            ok     = 1'b0;
        end else begin
            accept = 2 + 4 * n + 1;
            x = 8'd0;
            for (int i = 0; i < accept - 1; i++) x = x ^ frame_q[i];
            ok = (x == frame_q[accept - 1]);
        end
        if (n_send < 0 || n_send > accept) n_send = accept;
        partial = (n_send < accept);
        if (n <= CAP) begin
            for (int w = 0; w < n; w++) begin
                if (2 + 4 * w + 3 < n_send) begin
                    e.addr = w;
                    e.data = {frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]};
                    exp_q.push_back(e);
                end
            end
        end
        for (int i = 0; i < n_send; i++) begin
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (gap) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_data  = frame_q[i];
            rx_valid = 1'b1;
            start    = start_mid && (i == 3);
            chk("rx_ready_busy", 64'(rx_ready), 64'd1);
            if (!partial && i == n_send - 1) begin
                chk("pre_done", 64'(done), 64'd0);
                chk("pre_error", 64'(error), 64'd0);
            end
            @(posedge clk);
            if (n <= CAP && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
                lat_q.push_back(cyc + 1);
            @(negedge clk);
            start = 1'b0;
        end
        rx_valid = 1'b0;
        if (!partial) begin
            chk("done", 64'(done), 64'(ok));
            chk("error", 64'(error), 64'(!ok));
            chk("core_rst_n", 64'(core_rst_n), 64'(ok));
            chk("rx_ready_idle", 64'(rx_ready), 64'd0);
        end
        repeat (3) @(negedge clk);
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_error", 64'(error), 64'd0);
        chk("restart_rx_ready", 64'(rx_ready), 64'd1);
        chk("restart_core_rst_n", 64'(core_rst_n), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
        chk({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int n;
        logic [7:0] flip;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Two known words, back to back, then with random bubbles.
        word_in.delete();
        word_in.push_back(32'h8C220004);
        word_in.push_back(32'h00000013);
        build_frame(2, 8'h00);
        send_frame(0, -1, 1'b0);
        pulse_start();
        send_frame(5, -1, 1'b0);
        pulse_start();

        // Bad checksum, then a good frame after restart.
        rand_words(1);
        build_frame(1, 8'h01);
        send_frame(2, -1, 1'b0);
        pulse_start();
        rand_words(1);
        build_frame(1, 8'h00);
        send_frame(2, -1, 1'b0);
        pulse_start();

        // Capacity boundary: one past is rejected after the length, exact fit loads.
        rand_words(CAP + 1);
        build_frame(CAP + 1, 8'h00);
        send_frame(1, -1, 1'b0);
        pulse_start();
        rand_words(CAP);
        build_frame(CAP, 8'h00);
        send_frame(0, -1, 1'b0);
        pulse_start();

        // Empty image.
        word_in.delete();
        build_frame(0, 8'h00);
        send_frame(1, -1, 1'b0);
        pulse_start();
        build_frame(0, 8'h01);
        send_frame(1, -1, 1'b0);
        pulse_start();

        // Async reset after 6 payload bytes, then a fresh frame with a start
        // pulse landing on a byte transfer (must be ignored).
        rand_words(3);
        build_frame(3, 8'h00);
        send_frame(1, 8, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_words(3);
        build_frame(3, 8'h00);
        send_frame(3, -1, 1'b1);
        pulse_start();

        // Random frames, including oversize lengths and corrupted checksums.
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, CAP + 2);
            flip = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            rand_words(n);
            build_frame(n, flip);
            send_frame(3, -1, 1'b0);
            pulse_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
